moore_seq_detector: RTL
=======================

# moore_seq_detector

Parametrised Moore-type serial sequence detector, the generalised successor to the team's fixed 3-bit "110" detector. Detects an arbitrary PAT_W-bit pattern on a 1-bit serial input, with selectable overlapping or non-overlapping matching, an input-qualify enable, a synchronous clear and an optional saturating match counter. It sits on serial bit streams, for example framing or sync-word detection, and drives a registered, glitch-free match flag.

## Interface
- PAT_W, 3: pattern length in bits; legal range 1..16.
- PATTERN, 3'b110: pattern to detect. PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each detection.
- CNT_W, 8: width of match_cnt.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- in  input  1  serial data bit.
- in_en  input  1  when 1, in is sampled this edge; when 0, state holds.
- clear  input  1  synchronous clear of progress state and counter; overrides in_en.
- out  output  1  match flag; 1 while the FSM is in the MATCH state.
- match_cnt  output  CNT_W  number of detections, saturating.

## Operation
- State = match progress p, from 0 to PAT_W. States IDLE (p=0), S1..S(PAT_W-1) (partial prefix matched) and MATCH (p=PAT_W). State register width is clog2(PAT_W+1).
- out = (p == PAT_W). Moore: out depends only on the state register, never combinationally on in.
- Next state on an edge with in_en=1 and clear=0:
  - Let s be the string of the first p pattern bits followed by in. This uses p = PAT_W in MATCH when OVERLAP=1, and p = 0 in MATCH when OVERLAP=0.
  - The next p is the length of the longest suffix of s that is also a prefix of PATTERN, capped at PAT_W.
  - This is the KMP/failure-function transition, computed by a constant function or combinational loop. No lookup table is hand-written.
- in_en=0: p holds and out holds. A detection stays flagged until the next enabled edge.
- clear=1: p becomes 0 and match_cnt becomes 0 on the edge, regardless of in_en and in.
- PAT_W=1: IDLE and MATCH only. out mirrors the last enabled bit's equality with PATTERN[0].

## Timing
- Reset (rst=0, asynchronous): p=0, out=0, match_cnt=0 immediately, with no clock needed. Release is sampled on clk. The first enabled edge after release evaluates in normally.
- Latency: if the final pattern bit is sampled at edge N, out=1 from edge N until the next enabled edge.
- Back-to-back detections (OVERLAP=1, e.g. pattern 111 with an input of all 1s): out stays 1 continuously. match_cnt increments on every such edge.
- Reset asserted mid-sequence discards all partial progress. No detection straddles a reset or a clear.
- clear and in_en both 1 on the same edge: clear wins, and the bit is discarded.

## Configuration
- Macro MOORE_SEQ_CNT_EN.
- Defined:
  - match_cnt increments by 1 on every enabled edge whose next state is MATCH.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It clears on reset or clear.
- Not defined:
  - No counter logic is built.
  - match_cnt is tied to 0.
  - The port list is unchanged.

## Test plan
- Defaults (PATTERN=110), in_en=1, input 1,1,0 on edges 1-3:
  - out=0 through edge 2.
  - out=1 after edge 3, and back to 0 after edge 4 with in=1.
  - match_cnt=1.
- PAT_W=4, PATTERN=4'b1011, input 1,0,1,1,0,1,1:
  - OVERLAP=1: out pulses after edges 4 and 7, match_cnt=2.
  - OVERLAP=0: out pulses after edge 4 only, match_cnt=1.
- Reset mid-operation (defaults): input 1,1, then rst=0 between edges without a clock edge, then release and drive 0.
  - out=0 and state IDLE immediately on assertion.
  - No detection follows.
- in_en gaps (defaults): 1, (in_en=0 with in=0 for 3 edges), 1, 0.
  - Gapped bits are ignored.
  - out=1 after the final enabled edge.
  - While in MATCH, in_en=0 holds out=1.
- Clear priority and saturation (CNT_W=2, pattern 111, OVERLAP=1, input all 1s for 8 edges):
  - match_cnt counts 1,2,3, then holds at 3.
  - clear=1 with in_en=1, in=1 gives p=0, out=0, match_cnt=0.
- Macro off: the same stimulus as scenario 1 gives an identical out waveform, with match_cnt constant 0.

Source files
------------

// File: rtl/moore_seq_detector.sv
// Moore serial detector for a PAT_W-bit pattern, with a KMP transition table built at elaboration.
// Optional saturating match counter behind `MOORE_SEQ_CNT_EN; without it match_cnt is tied to 0.
module moore_seq_detector #(
    parameter int              PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_en,
    input  logic             clear,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int SW = $clog2(PAT_W + 1);
    localparam int TN = 2 ** (SW + 1);

    typedef enum logic [SW-1:0] {
        IDLE  = SW'(0),
        MATCH = SW'(PAT_W)
    } state_t;

    function automatic logic pat_bit(int i);
        logic [15:0] t;
        t = 16'(PATTERN) >> (PAT_W - 1 - i);
        return t[0];
    endfunction

    // Longest suffix of (first p pattern bits, b) that is also a pattern prefix.
    function automatic int kmp_next(int p, int b);
        int   pe;
        int   k0;
        int   idx;
        int   res;
        logic sb;
        logic ok;
        res = 0;
        if (p <= PAT_W) begin
            pe = (p == PAT_W && !OVERLAP) ? 0 : p;
            k0 = (pe + 1 > PAT_W) ? PAT_W : pe + 1;
            for (int k = k0; k >= 1; k--) begin
                if (res == 0) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        idx = pe + 1 - k + j;
                        sb  = (idx == pe) ? b[0] : pat_bit(idx);
                        if (sb != pat_bit(j)) ok = 1'b0;
                    end
                    if (ok) res = k;
                end
            end
        end
        return res;
    endfunction

    logic [SW-1:0] nxt_tab [TN];

    for (genvar g = 0; g < TN; g++) begin : g_tab
        assign nxt_tab[g] = SW'(kmp_next(g / 2, g % 2));
    end

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (in_en) begin
            state_d = state_t'(nxt_tab[{state_q, in}]);
        end
    end

    assign out = (state_q == MATCH);

`ifdef MOORE_SEQ_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;

    assign hit = in_en && !clear && (state_d == MATCH);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
